// File: rtl/jk_bank_driver_pkg.sv
// Shared state encodings and excitation-mode constants for the JK bank driver.
package jk_bank_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int EXC_SET_RESET = 0;
    localparam int EXC_TOGGLE    = 1;

endpackage

// File: rtl/jk_excite.sv
// Per-bit J/K excitation that moves a JK bank from its current Q to a target.
module jk_excite
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int TOGGLE_MODE = EXC_SET_RESET
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_next,
    output logic [WIDTH-1:0] k_next
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic diff;
        assign diff = target[i] ^ q[i];
        if (TOGGLE_MODE == EXC_TOGGLE) begin : g_tog
            assign j_next[i] = diff;
            assign k_next[i] = diff;
        end else begin : g_sr
            // Set toward a 1 target, reset toward a 0 target; never both.
            assign j_next[i] = diff & target[i];
            assign k_next[i] = diff & ~target[i];
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of external JK flip-flops to target words, verifying and retrying.
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int TOGGLE_MODE = 0,
    parameter int MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [3:0]       retries
);

    localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt, tgt_n;
    logic [3:0]       cnt, cnt_n;
    logic [WIDTH-1:0] j_n, k_n;
    logic             done_n, err_n;
    logic [3:0]       retries_n;
    logic [WIDTH-1:0] exc_tgt, j_x, k_x;

    // A single excitation unit serves both the accept and the retry path.
    assign exc_tgt  = (state == IDLE) ? in_data : tgt;
    assign in_ready = (state == IDLE);

    jk_excite #(
        .WIDTH      (WIDTH),
        .TOGGLE_MODE(TOGGLE_MODE)
    ) u_excite (
        .target(exc_tgt),
        .q     (q_fb),
        .j_next(j_x),
        .k_next(k_x)
    );

    always_comb begin
        state_n   = state;
        tgt_n     = tgt;
        cnt_n     = cnt;
        j_n       = '0;
        k_n       = '0;
        done_n    = 1'b0;
        err_n     = err;
        retries_n = retries;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    tgt_n   = in_data;
                    cnt_n   = '0;
                    j_n     = j_x;
                    k_n     = k_x;
                    state_n = DRIVE;
                end
            end
            DRIVE: state_n = CHECK;
            CHECK: begin
                if (q_fb == tgt) begin
                    state_n   = IDLE;
                    done_n    = 1'b1;
                    err_n     = 1'b0;
                    retries_n = cnt;
                end else if (cnt < MAX_R) begin
                    cnt_n   = cnt + 4'd1;
                    j_n     = j_x;
                    k_n     = k_x;
                    state_n = DRIVE;
                end else begin
                    state_n   = IDLE;
                    done_n    = 1'b1;
                    err_n     = 1'b1;
                    retries_n = cnt;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tgt     <= '0;
            cnt     <= '0;
            j       <= '0;
            k       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            retries <= '0;
        end else begin
            state   <= state_n;
            tgt     <= tgt_n;
            cnt     <= cnt_n;
            j       <= j_n;
            k       <= k_n;
            done    <= done_n;
            err     <= err_n;
            retries <= retries_n;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (set/reset and toggle excitation) each steering a modelled JK bank.
module tb_jk_bank_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic [3:0] q0 = '0, q1 = '0;
    logic [3:0] stuck = '0;
    logic [3:0] j0, k0, j1, k1, r0, r1;
    logic       rdy0, rdy1, done0, done1, err0, err1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(0), .MAX_RETRY(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .q_fb(q0), .j(j0), .k(k0), .done(done0), .err(err0), .retries(r0)
    );

    jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(1), .MAX_RETRY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .q_fb(q1), .j(j1), .k(k1), .done(done1), .err(err1), .retries(r1)
    );

    function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj,
                                           input logic [3:0] kk);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = (jj[i] & ~kk[i]) ? 1'b1 : (~jj[i] & kk[i]) ? 1'b0 :
                   (jj[i] & kk[i]) ? ~q[i] : q[i];
        return r;
    endfunction

    // Bank model; stuck bits are forced to 0 in the stored state.
    always @(posedge clk) begin
        q0 <= jk_next(q0, j0, k0) & ~stuck;
        q1 <= jk_next(q1, j1, k1) & ~stuck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_both(input string tag);
        check({tag, " j0"}, 32'(j0), 0);
        check({tag, " k0"}, 32'(k0), 0);
        check({tag, " j1"}, 32'(j1), 0);
        check({tag, " k1"}, 32'(k1), 0);
        check({tag, " rdy0"}, 32'(rdy0), 1);
        check({tag, " rdy1"}, 32'(rdy1), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;

        // 1. reset
        repeat (3) step();
        chk_idle_both("rst");
        check("rst done0", 32'(done0), 0);
        check("rst err0", 32'(err0), 0);
        check("rst ret0", 32'(r0), 0);
        check("rst done1", 32'(done1), 0);
        rst_n = 1'b1;
        repeat (2) step();
        chk_idle_both("post_rst");
        check("post_rst done0", 32'(done0), 0);

        // 2. 0000 -> 1010
        in_valid = 1'b1; in_data = 4'b1010;
        step();
        in_valid = 1'b0;
        check("t2 drive j0", 32'(j0), 32'b1010);
        check("t2 drive k0", 32'(k0), 32'b0000);
        check("t2 drive j1", 32'(j1), 32'b1010);
        check("t2 drive k1", 32'(k1), 32'b1010);
        check("t2 busy rdy0", 32'(rdy0), 0);
        step();
        check("t2 check q0", 32'(q0), 32'b1010);
        check("t2 check j0", 32'(j0), 0);
        check("t2 check done0", 32'(done0), 0);
        step();
        check("t2 done0", 32'(done0), 1);
        check("t2 err0", 32'(err0), 0);
        check("t2 ret0", 32'(r0), 0);
        check("t2 done1", 32'(done1), 1);
        check("t2 err1", 32'(err1), 0);
        step();
        check("t2 done0 pulse", 32'(done0), 0);

        // 3. 1010 -> 0110
        in_valid = 1'b1; in_data = 4'b0110;
        step();
        in_valid = 1'b0;
        check("t3 j0", 32'(j0), 32'b0100);
        check("t3 k0", 32'(k0), 32'b1000);
        check("t3 j1", 32'(j1), 32'b1100);
        check("t3 k1", 32'(k1), 32'b1100);
        repeat (2) step();
        check("t3 done0", 32'(done0), 1);
        check("t3 err0", 32'(err0), 0);
        check("t3 err1", 32'(err1), 0);
        check("t3 q0", 32'(q0), 32'b0110);
        check("t3 q1", 32'(q1), 32'b0110);

        // 4. target equals Q, then back-to-back 1111 accepted in the done cycle
        in_valid = 1'b1; in_data = 4'b0110;
        step();
        in_data = 4'b1111;
        check("t4 j0", 32'(j0), 0);
        check("t4 k0", 32'(k0), 0);
        check("t4 j1", 32'(j1), 0);
        step();
        check("t4 chk rdy0", 32'(rdy0), 0);
        step();
        check("t4 done0", 32'(done0), 1);
        check("t4 err0", 32'(err0), 0);
        check("t4 done rdy0", 32'(rdy0), 1);
        step();
        in_valid = 1'b0;
        check("t4b j0", 32'(j0), 32'b1001);
        check("t4b k0", 32'(k0), 32'b0000);
        check("t4b j1", 32'(j1), 32'b1001);
        check("t4b k1", 32'(k1), 32'b1001);
        check("t4b done0 low", 32'(done0), 0);
        step();
        step();
        check("t4b done0", 32'(done0), 1);
        check("t4b err0", 32'(err0), 0);
        check("t4b q0", 32'(q0), 32'b1111);
        check("t4b q1", 32'(q1), 32'b1111);

        // 5. clear the bank, then bit0 stuck-at-0 with target 0001
        in_valid = 1'b1; in_data = 4'b0000;
        step();
        in_valid = 1'b0;
        check("t5 clr k0", 32'(k0), 32'b1111);
        repeat (2) step();
        check("t5 clr done0", 32'(done0), 1);
        check("t5 clr q0", 32'(q0), 0);
        stuck = 4'b0001;
        in_valid = 1'b1; in_data = 4'b0001;
        step();
        in_valid = 1'b0;
        for (int a = 0; a < 3; a++) begin
            check($sformatf("t5 drive%0d j0", a), 32'(j0), 32'b0001);
            check($sformatf("t5 drive%0d k0", a), 32'(k0), 32'b0000);
            check($sformatf("t5 drive%0d j1", a), 32'(j1), 32'b0001);
            step();
            check($sformatf("t5 check%0d done0", a), 32'(done0), 0);
            step();
        end
        check("t5 done0", 32'(done0), 1);
        check("t5 err0", 32'(err0), 1);
        check("t5 ret0", 32'(r0), 2);
        check("t5 done1", 32'(done1), 1);
        check("t5 err1", 32'(err1), 1);
        check("t5 ret1", 32'(r1), 2);
        step();
        check("t5 err0 hold", 32'(err0), 1);
        check("t5 ret0 hold", 32'(r0), 2);
        stuck = 4'b0000;

        // 6. reset mid-DRIVE
        in_valid = 1'b1; in_data = 4'b1111;
        step();
        in_valid = 1'b0;
        check("t6 drive j0", 32'(j0), 32'b1111);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async j0", 32'(j0), 0);
        check("t6 async k0", 32'(k0), 0);
        check("t6 async j1", 32'(j1), 0);
        check("t6 async k1", 32'(k1), 0);
        check("t6 async rdy0", 32'(rdy0), 1);
        check("t6 async err0", 32'(err0), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t6 no done0", 32'(done0), 0);
        check("t6 no done1", 32'(done1), 0);
        check("t6 rdy0", 32'(rdy0), 1);
        check("t6 q0 held", 32'(q0), 0);
        in_valid = 1'b1; in_data = 4'b0101;
        step();
        in_valid = 1'b0;
        check("t6b j0", 32'(j0), 32'b0101);
        check("t6b j1", 32'(j1), 32'b0101);
        check("t6b k1", 32'(k1), 32'b0101);
        repeat (2) step();
        check("t6b done0", 32'(done0), 1);
        check("t6b err0", 32'(err0), 0);
        check("t6b ret0", 32'(r0), 0);
        check("t6b q0", 32'(q0), 32'b0101);
        check("t6b q1", 32'(q1), 32'b0101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
